// File: rtl/riscvibe_pkg.sv
// ---------------------------------------------------------------------------
// riscvibe_pkg
// Shared types and helpers for the load/store unit.
//   lsu_state_t      : LSU control states (IDLE, REQ, WAIT, RESP)
//   LSU_*            : funct3 memory-width encodings
//   lsu_width_legal  : 1 when the width is allowed for the access direction
//   lsu_misaligned   : 1 when the low address bits violate natural alignment
//   lsu_align_offset : low address bits with the misaligned part forced to 0
// ---------------------------------------------------------------------------
package riscvibe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   // Unsigned loads exist only for loads; stores of BU/HU are illegal.
   function automatic logic lsu_width_legal(input logic write, input logic [2:0] width);
      logic legal;
      case (width)
         LSU_B, LSU_H, LSU_W: legal = 1'b1;
         LSU_BU, LSU_HU:      legal = ~write;
         default:             legal = 1'b0;
      endcase
      return legal;
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] width, input logic [1:0] offset);
      logic mis;
      case (width)
         LSU_H, LSU_HU: mis = offset[0];
         LSU_W:         mis = |offset;
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [1:0] lsu_align_offset(input logic [2:0] width, input logic [1:0] offset);
      logic [1:0] aligned;
      case (width)
         LSU_H, LSU_HU: aligned = {offset[1], 1'b0};
         LSU_W:         aligned = 2'b00;
         default:       aligned = offset;
      endcase
      return aligned;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane logic of the load/store unit.
//   width      in  3  funct3 memory width
//   offset     in  2  byte offset inside the word
//   store_data in  32 raw store data
//   load_word  in  32 raw bus read word
//   be         out 4  byte enables
//   lane_data  out 32 store data replicated across the lanes
//   load_data  out 32 extracted and sign/zero-extended load data
// ---------------------------------------------------------------------------
module lsu_align
   import riscvibe_pkg::*;
(
   input  logic [2:0]  width,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] lane_data,
   output logic [31:0] load_data
);

   logic [31:0] shifted_s;

   // Lane selection, replication and extension per access width
   always_comb begin
      shifted_s = load_word >> {offset, 3'b000};
      be        = 4'b0000;
      lane_data = 32'd0;
      load_data = 32'd0;
      case (width)
         LSU_B: begin
            be        = 4'b0001 << offset;
            lane_data = {4{store_data[7:0]}};
            load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
         end
         LSU_BU: begin
            be        = 4'b0001 << offset;
            lane_data = {4{store_data[7:0]}};
            load_data = {24'd0, shifted_s[7:0]};
         end
         LSU_H: begin
            be        = 4'b0011 << {offset[1], 1'b0};
            lane_data = {2{store_data[15:0]}};
            load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
         end
         LSU_HU: begin
            be        = 4'b0011 << {offset[1], 1'b0};
            lane_data = {2{store_data[15:0]}};
            load_data = {16'd0, shifted_s[15:0]};
         end
         LSU_W: begin
            be        = 4'b1111;
            lane_data = store_data;
            load_data = shifted_s;
         end
         default: begin
            be        = 4'b0000;
            lane_data = 32'd0;
            load_data = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle request/response data-memory port between the execute stage
// and an external data bus. One access at a time; the core is stalled until
// the response pulse.
//   clk, rst_n (synchronous, active-low)
//   req_valid/req_write/req_addr/req_wdata/req_width/flush : core request
//   stall                                                   : core hold
//   rsp_valid/rsp_rdata/rsp_err                             : core response
//   bus_req_valid/ready/write/addr/wdata/be                 : bus request
//   bus_rsp_valid/rdata/err                                 : bus response
// Parameter TIMEOUT_CYCLES: WAIT cycles before a forced error (0 = never).
// Macro RISCVIBE_LSU_MISALIGN_TRAP_EN: misaligned accesses return an error
// without a bus transaction; otherwise they are aligned down.
// ---------------------------------------------------------------------------
module load_store_unit
   import riscvibe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_width,
   input  logic        flush,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_write,
   output logic [31:0] bus_req_addr,
   output logic [31:0] bus_req_wdata,
   output logic [3:0]  bus_req_be,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_rdata,
   input  logic        bus_rsp_err
);

   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   lsu_state_t  state_r;
   lsu_state_t  state_nxt_s;
   logic        write_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [2:0]  width_r;
   logic [31:0] rdata_r;
   logic        err_r;
   logic [31:0] wait_cnt_r;
   logic        accept_s;
   logic        reject_s;
   logic        timeout_s;
   logic [1:0]  offset_s;
   logic [3:0]  be_s;
   logic [31:0] lane_s;
   logic [31:0] load_s;

   // Request classification and timeout detection
   always_comb begin
      accept_s  = req_valid & ~flush;
      // The counter holds completed WAIT cycles, so the limit is hit during
      // the TIMEOUT_CYCLES-th WAIT cycle.
      timeout_s = (TIMEOUT_LIMIT != 32'd0) && ((wait_cnt_r + 32'd1) >= TIMEOUT_LIMIT);
`ifdef RISCVIBE_LSU_MISALIGN_TRAP_EN
      reject_s  = ~lsu_width_legal(req_write, req_width) | lsu_misaligned(req_width, req_addr[1:0]);
      offset_s  = req_addr[1:0];
`else
      reject_s  = ~lsu_width_legal(req_write, req_width);
      offset_s  = lsu_align_offset(req_width, req_addr[1:0]);
`endif
   end

   lsu_align u_align (
      .width      (width_r),
      .offset     (addr_r[1:0]),
      .store_data (wdata_r),
      .load_word  (bus_rsp_rdata),
      .be         (be_s),
      .lane_data  (lane_s),
      .load_data  (load_s)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic, stall and bus request outputs
   always_comb begin
      state_nxt_s   = state_r;
      stall         = 1'b0;
      rsp_valid     = 1'b0;
      bus_req_valid = 1'b0;
      bus_req_write = 1'b0;
      bus_req_addr  = 32'd0;
      bus_req_wdata = 32'd0;
      bus_req_be    = 4'b0000;
      case (state_r)
         IDLE: begin
            stall = accept_s;
            if (accept_s) begin
               if (reject_s) begin
                  state_nxt_s = RESP;
               end else begin
                  state_nxt_s = REQ;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            stall         = 1'b1;
            bus_req_valid = 1'b1;
            bus_req_write = write_r;
            bus_req_addr  = {addr_r[31:2], 2'b00};
            bus_req_wdata = lane_s;
            bus_req_be    = be_s;
            if (bus_req_ready) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = REQ;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (bus_rsp_valid || timeout_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP: begin
            rsp_valid   = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Latched request, timeout counter and registered response data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_r    <= 1'b0;
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
         width_r    <= 3'b000;
         rdata_r    <= 32'd0;
         err_r      <= 1'b0;
         wait_cnt_r <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  write_r <= req_write;
                  addr_r  <= {req_addr[31:2], offset_s};
                  wdata_r <= req_wdata;
                  width_r <= req_width;
                  err_r   <= reject_s;
                  rdata_r <= 32'd0;
               end
            end
            REQ: begin
               if (bus_req_ready) begin
                  wait_cnt_r <= 32'd0;
               end
            end
            WAIT: begin
               // A response in the timeout cycle takes priority.
               if (bus_rsp_valid) begin
                  err_r   <= bus_rsp_err;
                  rdata_r <= (bus_rsp_err | write_r) ? 32'd0 : load_s;
               end else if (timeout_s) begin
                  err_r   <= 1'b1;
                  rdata_r <= 32'd0;
               end else if (wait_cnt_r != TIMEOUT_LIMIT) begin
                  wait_cnt_r <= wait_cnt_r + 32'd1;
               end
            end
            RESP: begin
               err_r   <= 1'b0;
               rdata_r <= 32'd0;
            end
            default: begin
               err_r   <= 1'b0;
               rdata_r <= 32'd0;
            end
         endcase
      end
   end

   assign rsp_rdata = rdata_r;
   assign rsp_err   = err_r;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core execute stage and an external data bus, replacing the single-cycle data memory path with a multi-cycle request/response interface.
- Accepts one load/store per request.
- Generates word-aligned bus transactions with byte enables.
- Stalls the core until the response returns.
- Returns sign/zero-extended load data with error status.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in WAIT before an error response is forced; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  core requests an access this cycle
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
req_width  in  3  funct3 encoding: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
flush  in  1  cancels a req_valid presented in IDLE
stall  out  1  core must hold its state
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  bus error, timeout, illegal width or misaligned access
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts the request
bus_req_write  out  1  write strobe
bus_req_addr  out  32  word address, bits [1:0] = 00
bus_req_wdata  out  32  lane-replicated store data
bus_req_be  out  4  byte enables
bus_rsp_valid  in  1  bus response valid
bus_rsp_rdata  in  32  raw word read data
bus_rsp_err  in  1  bus error

Behaviour:
- Reset state: IDLE. All outputs 0 except stall, which is combinational: 0 unless req_valid=1.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_valid && !flush: latch write, addr, wdata, width.
  - Legal width and aligned address: go to REQ.
  - Illegal width (011, 110, 111; stores also 100, 101): go to RESP with err=1, no bus transaction.
  - req_valid && flush: ignored, stay IDLE.
- stall = (IDLE && req_valid && !flush) || REQ || WAIT. stall is 0 in RESP.
- REQ:
  - bus_req_valid=1; addr, wdata, be and write are held stable until bus_req_ready.
  - On ready, go to WAIT and clear the timeout counter.
- WAIT:
  - bus_rsp_valid: latch the formatted data and bus_rsp_err, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): go to RESP with err=1, rdata=0. The counter saturates.
  - A response arriving in the same cycle as the timeout wins over the timeout.
- RESP: rsp_valid=1 for exactly one cycle, outputs registered, then return to IDLE.
  - A new req_valid is not sampled in RESP.
- Minimum latency: request in cycle 0, bus_req_valid in cycle 1, ready in cycle 1, response in cycle 2, rsp_valid in cycle 3.
- Byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << {addr[1],1'b0}.
  - SW: 4'b1111.
- Store data: SB replicates byte[7:0] to all four lanes; SH replicates half[15:0] to both halves.
- Load data: the bus word is shifted right by addr[1:0]*8, then sign-extended (LB, LH) or zero-extended (LBU, LHU). LW passes through.
- rsp_err=1 forces rsp_rdata=0.
- Reset asserted mid-transaction: immediate return to IDLE and bus_req_valid drops. Reset is global, so this bus-protocol violation is accepted.

Optional Feature:
Macro RISCVIBE_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) issues no bus transaction. The FSM goes IDLE to RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: the offending low address bits are treated as 0 (access aligned down) and the access proceeds normally.

Decomposition:
- riscvibe_pkg gains:
  - lsu_state_t enum (IDLE, REQ, WAIT, RESP).
  - mem_width constants LSU_B=3'b000, LSU_H=3'b001, LSU_W=3'b010, LSU_BU=3'b100, LSU_HU=3'b101.
- One combinational sub-module, lsu_align: byte-enable generation, store-lane replication, and load extraction/extension. The FSM and timeout counter stay in load_store_unit.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, ready immediately, response one cycle later, err=0 -> bus_req_addr=0x100, be=1111; rsp_valid in cycle 3 with rdata=0, err=0; stall high for cycles 0–2.
2. LB addr 0x103, bus word 0x80FF_1234 -> rsp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
3. SB addr 0x201, data 0x5A -> be=0010, wdata=0x5A5A5A5A. Hold bus_req_ready=0 for 4 cycles -> all request fields stay stable and stall stays high.
4. TIMEOUT_CYCLES=8, no bus_rsp_valid -> rsp_valid with err=1 on the cycle after the 8th WAIT cycle. Repeat with the response arriving on the same cycle as the timeout -> normal response, err=0.
5. LW addr 0x102:
   - Macro on: no bus_req_valid; rsp_err=1 one cycle after the request.
   - Macro off: bus_req_addr=0x100 and the full word is returned.
6. req_valid with flush=1 -> no state change, stall=0. Width 3'b011 -> immediate err response. rst_n low while in WAIT -> next cycle IDLE with all outputs 0.
